// File: rtl/fft_stream_bridge_if.sv
// Stream and RAM signal bundle for fft_stream_bridge.
// The slave modport is the bridge. The master modport is the environment,
// which drives the input stream, the RAM read data and the output ready.
interface fft_stream_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);
    // Input sample stream
    logic                  i_in_valid;
    logic                  o_in_ready;
    logic [DATA_WIDTH-1:0] i_in_data;
    logic                  i_in_last;

    // FFT sample RAM port
    logic                  o_ram_we;
    logic [ADDR_WIDTH-1:0] o_ram_waddr;
    logic [DATA_WIDTH-1:0] o_ram_wdata;
    logic                  o_ram_re;
    logic [ADDR_WIDTH-1:0] o_ram_raddr;
    logic [DATA_WIDTH-1:0] i_ram_rdata;

    // Output result stream
    logic                  o_out_valid;
    logic                  i_out_ready;
    logic [DATA_WIDTH-1:0] o_out_data;
    logic                  o_out_last;

    modport slave (
        input  i_in_valid, i_in_data, i_in_last, i_ram_rdata, i_out_ready,
        output o_in_ready, o_ram_we, o_ram_waddr, o_ram_wdata,
               o_ram_re, o_ram_raddr, o_out_valid, o_out_data, o_out_last
    );

    modport master (
        output i_in_valid, i_in_data, i_in_last, i_ram_rdata, i_out_ready,
        input  o_in_ready, o_ram_we, o_ram_waddr, o_ram_wdata,
               o_ram_re, o_ram_raddr, o_out_valid, o_out_data, o_out_last
    );
endinterface

// File: rtl/fft_stream_bridge.sv
// FFT stream bridge: loads N streamed samples into the FFT RAM, hands the
// frame to the core, then streams N results back out through a credit-based
// skid FIFO. This keeps one beat per cycle under any RAM read latency.
module fft_stream_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = RD_LATENCY + 2
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [ADDR_WIDTH:0]   i_samples_number,
    input  logic                  i_abort,
    input  logic                  i_calc_end,
    output logic                  o_data_loaded,
    output logic                  o_done,
    output logic                  o_err_len,
    output logic                  o_busy,
    fft_stream_bridge_if.slave    io_bus
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [OCC_W:0]   OCC_LIMIT = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_UNLOAD,
        S_DRAIN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_run;

    logic [CNT_W-1:0]      r_n;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      w_n_eff;

    logic                  w_in_ready;
    logic                  w_in_fire;
    logic                  w_wr_last;
    logic                  w_rd_issue;
    logic                  w_rd_last;

    logic                  r_data_loaded;
    logic                  r_done;
    logic                  r_err_len;

    // Read-return tracking: one valid/last bit per cycle of RAM latency
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [RD_LATENCY-1:0] r_pipe_last;
    logic [OCC_W-1:0]      r_inflight;

    // Skid FIFO
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_last;
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit_ok;
    logic                  w_head_last;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Input acceptance: only IDLE (with a non-zero length) and LOAD take samples
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_in_ready = 1'b0;
        if (r_run) begin
            if (r_state == S_IDLE) begin
                w_in_ready = (i_samples_number != '0);
            end else if (r_state == S_LOAD) begin
                w_in_ready = 1'b1;
            end
        end
    end

    assign w_in_fire   = io_bus.i_in_valid & w_in_ready;
    // In IDLE the length has not been latched yet, so frame the first beat against the live input
    assign w_n_eff     = (r_state == S_IDLE) ? i_samples_number : r_n;
    assign w_wr_last   = (r_wr_cnt == (w_n_eff - CNT_ONE));
    assign w_rd_last   = (r_rd_cnt == (r_n - CNT_ONE));
    // Reads in flight are counted against FIFO space so that a return always has a free slot
    assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_inflight}) < OCC_LIMIT;
    assign w_push      = r_pipe_vld[RD_LATENCY-1];
    assign w_pop       = (r_count != '0) & io_bus.i_out_ready;
    assign w_head_last = r_fifo_last[r_rptr];

    // Next-state and read-issue decode; abort overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        w_rd_issue  = 1'b0;
        unique case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_in_fire) begin
                    w_state_nxt = w_wr_last ? S_WAIT : S_LOAD;
                end
            end
            S_WAIT: begin
                if (i_calc_end) begin
                    w_state_nxt = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                w_rd_issue = w_credit_ok;
                if (w_credit_ok && w_rd_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    // State register; r_run keeps o_in_ready low until the first edge after reset release
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    // Frame length, write/read counters and status pulses
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_n           <= '0;
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_data_loaded <= 1'b0;
            r_done        <= 1'b0;
            r_err_len     <= 1'b0;
        end else begin
            r_data_loaded <= (w_state_nxt == S_WAIT) && (r_state != S_WAIT);
            r_done        <= (r_state == S_DRAIN) && w_pop && w_head_last && !i_abort;
            r_err_len     <= w_in_fire && (io_bus.i_in_last != w_wr_last);
            if (w_in_fire && (r_state == S_IDLE)) begin
                r_n <= i_samples_number;
            end
            if (i_abort) begin
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_in_fire) begin
                    r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CNT_ONE;
                end
                if ((r_state == S_WAIT) && i_calc_end) begin
                    r_rd_cnt <= '0;
                end else if (w_rd_issue) begin
                    r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + CNT_ONE;
                end
            end
        end
    end

    // Read-latency pipeline and in-flight counter; abort discards pending returns
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_inflight  <= '0;
        end else if (i_abort) begin
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_inflight  <= '0;
        end else begin
            r_pipe_vld[0]  <= w_rd_issue;
            r_pipe_last[0] <= w_rd_issue & w_rd_last;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_last[k] <= r_pipe_last[k-1];
            end
            unique case ({w_rd_issue, w_push})
                2'b10:   r_inflight <= r_inflight + OCC_ONE;
                2'b01:   r_inflight <= r_inflight - OCC_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Skid FIFO capturing RAM returns and feeding the output stream
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            // NOTE: the FIFO storage is small and its head drives o_out_data, so it is reset to keep outputs at 0.
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_fifo_data[k] <= '0;
            end
            r_fifo_last <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else if (i_abort) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= io_bus.i_ram_rdata;
                r_fifo_last[r_wptr] <= r_pipe_last[RD_LATENCY-1];
                r_wptr              <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_ONE;
                2'b01:   r_count <= r_count - OCC_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign io_bus.o_in_ready  = w_in_ready;
    assign io_bus.o_ram_we    = w_in_fire;
    assign io_bus.o_ram_waddr = r_wr_cnt[ADDR_WIDTH-1:0];
    assign io_bus.o_ram_wdata = w_in_fire ? io_bus.i_in_data : '0;
    assign io_bus.o_ram_re    = w_rd_issue;
    assign io_bus.o_ram_raddr = r_rd_cnt[ADDR_WIDTH-1:0];
    assign io_bus.o_out_valid = (r_count != '0);
    assign io_bus.o_out_data  = r_fifo_data[r_rptr];
    assign io_bus.o_out_last  = (r_count != '0) & w_head_last;

    assign o_data_loaded = r_data_loaded;
    assign o_done        = r_done;
    assign o_err_len     = r_err_len;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fft_stream_bridge.sv
// Directed bench for fft_stream_bridge: RAM model, per-cycle output scoreboard,
// framing/abort/reset scenarios with hand-derived expectations.
module tb_fft_stream_bridge;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = RD_LAT + 2;

    logic          i_clk;
    logic          i_rstn;
    logic [AW:0]   i_samples_number;
    logic          i_abort;
    logic          i_calc_end;
    logic          o_data_loaded;
    logic          o_done;
    logic          o_err_len;
    logic          o_busy;

    fft_stream_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

    fft_stream_bridge #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(RD_LAT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_samples_number (i_samples_number),
        .i_abort          (i_abort),
        .i_calc_end       (i_calc_end),
        .o_data_loaded    (o_data_loaded),
        .o_done           (o_done),
        .o_err_len        (o_err_len),
        .o_busy           (o_busy),
        .io_bus           (bus_if)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM model with RD_LAT cycles of read latency
    logic [DW-1:0] ram_mem  [16];
    logic [DW-1:0] ram_pipe [RD_LAT];
    always @(posedge i_clk) begin
        if (bus_if.o_ram_we) ram_mem[bus_if.o_ram_waddr] <= bus_if.o_ram_wdata;
        ram_pipe[0] <= bus_if.o_ram_re ? ram_mem[bus_if.o_ram_raddr] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign bus_if.i_ram_rdata = ram_pipe[RD_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard state (bench-side expectations)
    logic [DW-1:0] exp_mem [16];
    int            exp_n = 1;
    int            mon_beat = 0;
    int            mon_beats_total = 0;
    int            mon_issued = 0;
    int            mon_accepted = 0;
    logic          mon_stalled = 1'b0;
    logic [DW-1:0] mon_prev_data = '0;
    logic          mon_prev_last = 1'b0;
    int            cnt_loaded = 0;
    int            cnt_err = 0;
    int            cnt_done = 0;

    // Per-cycle observation, called after inputs of the cycle have settled
    task automatic monitor();
        if (o_data_loaded) cnt_loaded++;
        if (o_err_len)     cnt_err++;
        if (o_done)        cnt_done++;
        if (bus_if.o_ram_re) begin
            mon_issued++;
            check("fifo_credit", 64'((mon_issued - mon_accepted) <= DEPTH), 64'd1);
        end
        if (bus_if.o_out_valid && mon_stalled) begin
            check("stall_data", bus_if.o_out_data, mon_prev_data);
            check("stall_last", bus_if.o_out_last, mon_prev_last);
        end
        if (bus_if.o_out_valid && bus_if.i_out_ready) begin
            check("out_data", bus_if.o_out_data, exp_mem[mon_beat[3:0]]);
            check("out_last", bus_if.o_out_last, 64'(mon_beat == exp_n - 1));
            mon_accepted++;
            mon_beats_total++;
            mon_beat = (mon_beat == exp_n - 1) ? 0 : mon_beat + 1;
        end
        mon_stalled   = bus_if.o_out_valid && !bus_if.i_out_ready;
        mon_prev_data = bus_if.o_out_data;
        mon_prev_last = bus_if.o_out_last;
        if (i_abort || !i_rstn) begin
            mon_beat     = 0;
            mon_issued   = 0;
            mon_accepted = 0;
            mon_stalled  = 1'b0;
        end
    endtask

    task automatic end_cycle();
        monitor();
        @(negedge i_clk);
    endtask

    // Stream n samples back-to-back; i_in_last follows mask
    task automatic load_frame(input int n, input logic [15:0] mask, input logic [DW-1:0] seed);
        logic [DW-1:0] d;
        exp_n = n;
        i_samples_number = (AW + 1)'(n);
        for (int i = 0; i < n; i++) begin
            d = seed + DW'(i) * 32'h0100_0003;
            bus_if.i_in_valid = 1'b1;
            bus_if.i_in_data  = d;
            bus_if.i_in_last  = mask[i];
            exp_mem[i] = d;
            #1;
            check("in_ready", bus_if.o_in_ready, 1);
            check("ram_we", bus_if.o_ram_we, 1);
            check("ram_waddr", bus_if.o_ram_waddr, 64'(i % 16));
            check("ram_wdata", bus_if.o_ram_wdata, d);
            if (i > 0) check("err_len_beat", o_err_len, 64'(mask[i-1]));
            end_cycle();
        end
        bus_if.i_in_valid = 1'b0;
        bus_if.i_in_last  = 1'b0;
        #1;
        check("err_len_final", o_err_len, 64'(!mask[n-1]));
        check("data_loaded", o_data_loaded, 1);
        check("wait_ready", bus_if.o_in_ready, 0);
        check("wait_busy", o_busy, 1);
        end_cycle();
        #1;
        check("data_loaded_once", o_data_loaded, 0);
        end_cycle();
    endtask

    // Kick the core done and drain n beats; mode 0 = ready high, mode 1 = toggle with a long stall
    task automatic unload(input int n, input int mode);
        int first_rd  = -1;
        int first_vld = -1;
        int last_c    = -1;
        int beats0    = mon_beats_total;
        logic done_seen = 1'b0;
        i_calc_end = 1'b1;
        bus_if.i_out_ready = 1'b1;
        #1;
        end_cycle();
        i_calc_end = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (mode == 0) bus_if.i_out_ready = 1'b1;
            else bus_if.i_out_ready = (c >= 8 && c < 18) ? 1'b0 : (c % 2 == 0);
            #1;
            if (bus_if.o_ram_re && first_rd < 0) first_rd = c;
            if (bus_if.o_out_valid && first_vld < 0) first_vld = c;
            if (bus_if.o_out_valid && bus_if.i_out_ready && bus_if.o_out_last) last_c = c;
            if (o_done) begin
                done_seen = 1'b1;
                check("done_idle", o_busy, 0);
            end
            end_cycle();
        end
        check("done_seen", done_seen, 1);
        check("beat_count", 64'(mon_beats_total - beats0), 64'(n));
        check("first_valid_latency", 64'(first_vld - first_rd), 64'(RD_LAT + 1));
        if (mode == 0) check("throughput", 64'(last_c - first_vld), 64'(n - 1));
    endtask

    int e0, l0, d0, rd_seen;

    initial begin
        i_rstn = 1'b0;
        i_samples_number = 5'd8;
        i_abort = 1'b0;
        i_calc_end = 1'b0;
        bus_if.i_in_valid = 1'b0;
        bus_if.i_in_data = '0;
        bus_if.i_in_last = 1'b0;
        bus_if.i_out_ready = 1'b0;

        // Reset state
        @(negedge i_clk);
        #1;
        check("rst_in_ready", bus_if.o_in_ready, 0);
        check("rst_busy", o_busy, 0);
        check("rst_out_valid", bus_if.o_out_valid, 0);
        check("rst_ram_re", bus_if.o_ram_re, 0);
        check("rst_pulses", {o_done, o_err_len, o_data_loaded}, 0);
        i_rstn = 1'b1;
        @(negedge i_clk);
        #1;
        check("ready_after_rst", bus_if.o_in_ready, 1);
        end_cycle();

        // N=8 nominal frame
        e0 = cnt_err;
        load_frame(8, 16'h0080, 32'h1000_0000);
        check("n8_no_err", 64'(cnt_err - e0), 0);
        unload(8, 0);

        // N=16 (full address range) with backpressure
        load_frame(16, 16'h8000, 32'h2000_0010);
        unload(16, 1);

        // N=4 with misplaced last
        e0 = cnt_err;
        load_frame(4, 16'h0004, 32'h3000_0020);
        check("n4_err_count", 64'(cnt_err - e0), 2);
        unload(4, 0);

        // N=1
        load_frame(1, 16'h0001, 32'h4000_0030);
        unload(1, 0);

        // Abort in UNLOAD after 3 reads
        load_frame(8, 16'h0080, 32'h5000_0040);
        l0 = cnt_loaded;
        d0 = cnt_done;
        rd_seen = 0;
        i_calc_end = 1'b1;
        bus_if.i_out_ready = 1'b0;
        #1;
        end_cycle();
        i_calc_end = 1'b0;
        for (int c = 0; c < 20 && rd_seen < 3; c++) begin
            #1;
            if (bus_if.o_ram_re) rd_seen++;
            end_cycle();
        end
        check("abort_reads_seen", 64'(rd_seen), 3);
        i_abort = 1'b1;
        #1;
        end_cycle();
        i_abort = 1'b0;
        bus_if.i_out_ready = 1'b1;
        #1;
        check("abort_busy", o_busy, 0);
        check("abort_out_valid", bus_if.o_out_valid, 0);
        check("abort_ram_re", bus_if.o_ram_re, 0);
        end_cycle();
        for (int c = 0; c < 6; c++) begin
            #1;
            check("abort_late_drop", bus_if.o_out_valid, 0);
            end_cycle();
        end
        check("abort_no_pulses", 64'((cnt_loaded - l0) + (cnt_done - d0)), 0);
        load_frame(8, 16'h0080, 32'h6000_0050);
        unload(8, 0);

        // Zero length holds off input
        i_samples_number = '0;
        bus_if.i_in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("zero_n_ready", bus_if.o_in_ready, 0);
            check("zero_n_we", bus_if.o_ram_we, 0);
            end_cycle();
        end

        // Asynchronous reset mid-LOAD
        i_samples_number = 5'd8;
        for (int i = 0; i < 3; i++) begin
            bus_if.i_in_data = 32'h7000_0000 + DW'(i);
            #1;
            end_cycle();
        end
        #1;
        check("mid_load_busy", o_busy, 1);
        #1;
        i_rstn = 1'b0;
        #1;
        check("arst_in_ready", bus_if.o_in_ready, 0);
        check("arst_we", bus_if.o_ram_we, 0);
        check("arst_wdata", bus_if.o_ram_wdata, 0);
        check("arst_waddr", bus_if.o_ram_waddr, 0);
        check("arst_busy", o_busy, 0);
        check("arst_out", {bus_if.o_out_valid, bus_if.o_ram_re, o_done, o_err_len, o_data_loaded}, 0);
        bus_if.i_in_valid = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        @(negedge i_clk);
        #1;
        check("rst2_ready", bus_if.o_in_ready, 1);
        end_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_stream_bridge.md
Name: fft_stream_bridge

Overview:
- Parametrised successor to the FFT sample bridge.
- Accepts N input samples over a valid/ready stream and writes them to the FFT sample RAM, then signals the core.
- After the core's calc-end, reads N results from RAM (configurable read latency) and emits them on a valid/ready output stream with full backpressure support.
- Adds runtime length latching, last-beat framing with length-error reporting, synchronous abort, and a skid FIFO so throughput is 1 sample/cycle.

Parameters:
- DATA_WIDTH, 32, sample word width.
- ADDR_WIDTH, 12, RAM index width; max N = 2^ADDR_WIDTH.
- RD_LATENCY, 1, RAM read latency in cycles (1..4).
- FIFO_DEPTH, RD_LATENCY+2, output skid FIFO depth (>= RD_LATENCY+1).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_samples_number  in  ADDR_WIDTH+1  N, latched on first accepted input beat
- i_abort  in  1  synchronous flush to IDLE
- i_in_valid  in  1  input stream valid
- o_in_ready  out  1  input stream ready
- i_in_data  in  DATA_WIDTH  input sample
- i_in_last  in  1  input framing marker
- o_ram_we  out  1  RAM write enable
- o_ram_waddr  out  ADDR_WIDTH  RAM write index
- o_ram_wdata  out  DATA_WIDTH  RAM write data
- o_ram_re  out  1  RAM read enable
- o_ram_raddr  out  ADDR_WIDTH  RAM read index
- i_ram_rdata  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after o_ram_re
- o_data_loaded  out  1  1-cycle pulse: frame in RAM
- i_calc_end  in  1  FFT done pulse
- o_out_valid  out  1  output stream valid
- i_out_ready  in  1  output stream ready
- o_out_data  out  DATA_WIDTH  output sample
- o_out_last  out  1  marks sample N-1
- o_done  out  1  1-cycle pulse: last output beat accepted
- o_err_len  out  1  1-cycle pulse: framing mismatch
- o_busy  out  1  state != IDLE

Behaviour:
- Reset: i_rstn, asynchronous, active-low; clock i_clk. Under reset all outputs, counters, the FIFO and the N register are 0, and the state is IDLE. o_in_ready rises in the first cycle after reset release.
- States: IDLE, LOAD, WAIT, UNLOAD, DRAIN.
- Input handshake fires when i_in_valid & o_in_ready. On each handshake, in the same cycle:
  - o_ram_we=1
  - o_ram_waddr=wr_cnt
  - o_ram_wdata=i_in_data
- IDLE:
  - o_in_ready=1 if i_samples_number != 0, else 0 (no transfer).
  - On handshake: latch N, write index 0, wr_cnt=1, go to LOAD. If N==1, go directly to WAIT instead.
- LOAD:
  - o_in_ready=1; each handshake writes index wr_cnt and increments it.
  - The handshake with wr_cnt==N-1 moves to WAIT and clears wr_cnt.
  - Later changes to i_samples_number are ignored.
- o_data_loaded: 1-cycle pulse in the first cycle of WAIT.
- Framing: o_err_len pulses in the cycle after a handshake where i_in_last != (index==N-1). The frame still ends on count; i_in_last never terminates it.
- WAIT:
  - o_in_ready=0.
  - i_calc_end moves to UNLOAD, with rd_cnt=0.
  - i_calc_end is ignored in every other state.
- UNLOAD:
  - o_ram_re=1 and o_ram_raddr=rd_cnt whenever credits allow: (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - rd_cnt increments per issued read; after read N-1 is issued, go to DRAIN.
- Read return: i_ram_rdata is pushed into the FIFO at the clock edge ending cycle t+RD_LATENCY for a read issued in cycle t. The FIFO never overflows.
- Output:
  - o_out_valid = FIFO not empty; o_out_data = FIFO head.
  - o_out_last=1 on the head carrying index N-1.
  - Pop on o_out_valid & i_out_ready. Data and last are stable while valid & !ready.
- First o_out_valid appears RD_LATENCY+1 cycles after the first read. With i_out_ready held high, the rate is 1 beat/cycle sustained.
- DRAIN: no reads issued. Acceptance of the last beat pulses o_done in the next cycle and returns to IDLE.
- i_abort (any state):
  - Next cycle: IDLE, counters and FIFO cleared, in-flight read returns discarded.
  - No o_done or o_data_loaded pulse.
  - RAM contents are not cleared.
- Simultaneous i_abort and handshake: the abort wins and the write still occurs in that cycle.
- Reset mid-operation behaves as abort, but asynchronously.
- N == 2^ADDR_WIDTH is legal: counters are ADDR_WIDTH+1 bits wide, and addresses use the low ADDR_WIDTH bits.

Test Plan:
- N=8, continuous input valid, i_in_last on beat 7 -> writes to indices 0..7, o_data_loaded one cycle after beat 7, no o_err_len. i_calc_end -> 8 output beats equal to the RAM contents, o_out_last on beat 8, o_done pulse, state returns to IDLE.
- N=16, RD_LATENCY=3, i_out_ready toggled 1010... and held low for 10 cycles -> no data lost or duplicated, o_out_data stable while stalled, FIFO never exceeds FIFO_DEPTH.
- N=4, i_in_last asserted on beat 2 and absent on beat 3 -> o_err_len pulses twice; all 4 samples are still written and WAIT is reached.
- N=1 -> a single beat goes directly to WAIT; one output beat carries both o_out_last and o_done.
- i_abort asserted in UNLOAD after 3 of 8 reads -> next cycle o_busy=0, o_out_valid=0, late RAM returns are dropped; a following N=8 frame completes correctly.
- i_samples_number=0 -> o_in_ready stays 0. Asynchronous reset asserted mid-LOAD -> all outputs 0 immediately.
